// File: rtl/wvb_rd_sched_pkg.sv
// -----------------------------------------------------------------------------
// wvb_rd_sched_pkg
// Shared definitions for the waveform-buffer readout scheduler:
//   - state_e                   : scheduler FSM state encoding
//   - L_WVB_RD_TIMEOUT_DEFAULT  : default readout timeout in cycles
//   - L_TMO_WIDTH               : width of the timeout counter
// -----------------------------------------------------------------------------
package wvb_rd_sched_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ARB   = 3'd1,
      ST_START = 3'd2,
      ST_WAIT  = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   localparam int L_WVB_RD_TIMEOUT_DEFAULT = 65535;
   localparam int L_TMO_WIDTH              = 16;

endpackage : wvb_rd_sched_pkg

// File: rtl/wvb_rr_pick.sv
// -----------------------------------------------------------------------------
// wvb_rr_pick
// Combinational round-robin picker: rotates the request vector so that bit
// ptr_i lands at position 0, priority-encodes the lowest set bit, then rotates
// the result back into an absolute channel index.
//
// Ports:
//   req_i    in  P_N    request vector (1 = channel wants service)
//   ptr_i    in  P_W    search start position (must be < P_N)
//   found_o  out 1      at least one request bit is set
//   idx_o    out P_W    first requesting channel at or above ptr_i (wrapping)
// -----------------------------------------------------------------------------
module wvb_rr_pick #(
   parameter int P_N = 24,
   parameter int P_W = 5
) (
   input  logic [P_N-1:0] req_i,
   input  logic [P_W-1:0] ptr_i,
   output logic           found_o,
   output logic [P_W-1:0] idx_o
);

   localparam int L_IW = (P_N > 1) ? $clog2(P_N) : 1;

   logic [P_N-1:0] rot;
   logic [P_W:0]   ofs;
   logic [P_W:0]   sum;

   // NOTE: every variable written here gets a default first so no path leaves
   // it unassigned; otherwise synthesis would infer a latch to hold its value.
   always_comb begin
      rot     = '0;
      ofs     = '0;
      sum     = '0;
      found_o = 1'b0;
      idx_o   = '0;

      for (int i = 0; i < P_N; i++) begin
         rot[i] = req_i[L_IW'((i + int'(ptr_i)) % P_N)];
      end

      // Scan from the top down so the lowest set bit is the one that sticks.
      for (int i = P_N - 1; i >= 0; i--) begin
         if (rot[i]) begin
            found_o = 1'b1;
            ofs     = (P_W+1)'(i);
         end
      end

      // Rotate back: one extra bit absorbs ptr + offset before the wrap.
      sum = {1'b0, ptr_i} + ofs;
      if (sum >= (P_W+1)'(P_N)) begin
         sum = sum - (P_W+1)'(P_N);
      end
      idx_o = sum[P_W-1:0];
   end

endmodule : wvb_rr_pick

// File: rtl/wvb_rd_sched.sv
// -----------------------------------------------------------------------------
// wvb_rd_sched
// Round-robin readout scheduler for the per-channel waveform buffers. Picks the
// next channel with a non-empty header FIFO, starts one readout at a time on the
// shared readout engine, and strobes chan_rddone_o back to the served channel.
//
// Compile-time option:
//   WVB_OVF_PRIO_EN  when defined, channels flagging chan_overflow_i are
//                    searched first (round-robin among themselves); otherwise
//                    the search is pure round-robin and chan_overflow_i is unused.
//
// Ports:
//   clk              in  1       system clock
//   rst              in  1       asynchronous active-high reset
//   en_i             in  1       enable; low blocks new readouts only
//   hdr_empty_i      in  N       per-channel header FIFO empty flags
//   chan_overflow_i  in  N       per-channel overflow flags
//   rd_start_o       out 1       one-cycle start pulse for rd_chan_o
//   rd_chan_o        out CW      channel being served
//   rd_busy_o        out 1       readout in progress (START through DONE)
//   rd_done_i        in  1       readout engine completion pulse
//   chan_rddone_o    out N       one-hot completion strobe to the served channel
//   timeout_err_o    out 1       sticky readout-timeout flag
//   err_clr_i        in  1       clears timeout_err_o
//   n_served_o       out 32      completed readout count (wraps)
// -----------------------------------------------------------------------------
module wvb_rd_sched
   import wvb_rd_sched_pkg::*;
#(
   parameter int P_N_CHAN     = 24,
   parameter int P_CHAN_WIDTH = 5,
   parameter int P_TIMEOUT    = L_WVB_RD_TIMEOUT_DEFAULT
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en_i,
   input  logic [P_N_CHAN-1:0]     hdr_empty_i,
   input  logic [P_N_CHAN-1:0]     chan_overflow_i,
   output logic                    rd_start_o,
   output logic [P_CHAN_WIDTH-1:0] rd_chan_o,
   output logic                    rd_busy_o,
   input  logic                    rd_done_i,
   output logic [P_N_CHAN-1:0]     chan_rddone_o,
   output logic                    timeout_err_o,
   input  logic                    err_clr_i,
   output logic [31:0]             n_served_o
);

   localparam logic [L_TMO_WIDTH-1:0]  L_TMO_LAST = L_TMO_WIDTH'(P_TIMEOUT - 1);
   localparam logic [P_CHAN_WIDTH-1:0] L_LAST_CH  = P_CHAN_WIDTH'(P_N_CHAN - 1);

   state_e                  state_q;
   logic [P_CHAN_WIDTH-1:0] ptr_q;
   logic [L_TMO_WIDTH-1:0]  tmo_cnt_q;
   logic                    rd_start_q;
   logic [P_CHAN_WIDTH-1:0] rd_chan_q;
   logic                    rd_busy_q;
   logic [P_N_CHAN-1:0]     chan_rddone_q;
   logic                    timeout_err_q;
   logic [31:0]             n_served_q;

   logic [P_N_CHAN-1:0]     req;
   logic                    pick_found;
   logic [P_CHAN_WIDTH-1:0] pick_idx;
   logic                    norm_found;
   logic [P_CHAN_WIDTH-1:0] norm_idx;
   logic [P_CHAN_WIDTH-1:0] ptr_d;

   assign req = ~hdr_empty_i;

   wvb_rr_pick #(
      .P_N (P_N_CHAN),
      .P_W (P_CHAN_WIDTH)
   ) u_pick_norm (
      .req_i   (req),
      .ptr_i   (ptr_q),
      .found_o (norm_found),
      .idx_o   (norm_idx)
   );

`ifdef WVB_OVF_PRIO_EN
   logic                    ovf_found;
   logic [P_CHAN_WIDTH-1:0] ovf_idx;

   wvb_rr_pick #(
      .P_N (P_N_CHAN),
      .P_W (P_CHAN_WIDTH)
   ) u_pick_ovf (
      .req_i   (req & chan_overflow_i),
      .ptr_i   (ptr_q),
      .found_o (ovf_found),
      .idx_o   (ovf_idx)
   );

   // Overflowing channels drain first; fall back to plain round-robin.
   assign pick_found = ovf_found | norm_found;
   assign pick_idx   = ovf_found ? ovf_idx : norm_idx;
`else
   logic chan_overflow_unused;

   assign chan_overflow_unused = ^chan_overflow_i;
   assign pick_found           = norm_found;
   assign pick_idx             = norm_idx;
`endif

   assign ptr_d = (rd_chan_q == L_LAST_CH) ? '0 : rd_chan_q + 1'b1;

   // NOTE: sequential state is updated with non-blocking assignments only, so
   // every flop samples the pre-edge values and a later assignment to the same
   // register in this block overrides an earlier one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         ptr_q         <= '0;
         tmo_cnt_q     <= '0;
         rd_start_q    <= 1'b0;
         rd_chan_q     <= '0;
         rd_busy_q     <= 1'b0;
         chan_rddone_q <= '0;
         timeout_err_q <= 1'b0;
         n_served_q    <= '0;
      end else begin
         rd_start_q    <= 1'b0;
         chan_rddone_q <= '0;

         // A timeout set in the WAIT branch below overrides this clear.
         if (err_clr_i) begin
            timeout_err_q <= 1'b0;
         end

         case (state_q)
            ST_IDLE: begin
               if (en_i && !(&hdr_empty_i)) begin
                  state_q <= ST_ARB;
               end
            end

            ST_ARB: begin
               // The request may have vanished since IDLE saw it.
               if (pick_found) begin
                  rd_chan_q  <= pick_idx;
                  rd_start_q <= 1'b1;
                  rd_busy_q  <= 1'b1;
                  state_q    <= ST_START;
               end else begin
                  state_q <= ST_IDLE;
               end
            end

            ST_START: begin
               tmo_cnt_q <= '0;
               state_q   <= ST_WAIT;
            end

            ST_WAIT: begin
               // rd_done is checked first so a coincident timeout counts as done.
               if (rd_done_i) begin
                  chan_rddone_q <= P_N_CHAN'(1) << rd_chan_q;
                  n_served_q    <= n_served_q + 32'd1;
                  state_q       <= ST_DONE;
               end else if (tmo_cnt_q == L_TMO_LAST) begin
                  timeout_err_q <= 1'b1;
                  state_q       <= ST_DONE;
               end else begin
                  tmo_cnt_q <= tmo_cnt_q + 1'b1;
               end
            end

            ST_DONE: begin
               ptr_q     <= ptr_d;
               rd_busy_q <= 1'b0;
               state_q   <= ST_IDLE;
            end

            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign rd_start_o    = rd_start_q;
   assign rd_chan_o     = rd_chan_q;
   assign rd_busy_o     = rd_busy_q;
   assign chan_rddone_o = chan_rddone_q;
   assign timeout_err_o = timeout_err_q;
   assign n_served_o    = n_served_q;

endmodule : wvb_rd_sched

// File: tb/tb_wvb_rd_sched.sv
// -----------------------------------------------------------------------------
// tb_wvb_rd_sched
// Directed self-checking bench for wvb_rd_sched (24 channels, timeout 16).
// Expected channel order is queued when requests are raised and popped when
// the scheduler issues rd_start. Outputs are sampled 1 ns after each rising
// edge; inputs are driven at the same point.
// -----------------------------------------------------------------------------
module tb_wvb_rd_sched;

   localparam int N  = 24;
   localparam int CW = 5;
   localparam int TO = 16;

   logic          clk;
   logic          rst;
   logic          en_i;
   logic [N-1:0]  hdr_empty_i;
   logic [N-1:0]  chan_overflow_i;
   logic          rd_start_o;
   logic [CW-1:0] rd_chan_o;
   logic          rd_busy_o;
   logic          rd_done_i;
   logic [N-1:0]  chan_rddone_o;
   logic          timeout_err_o;
   logic          err_clr_i;
   logic [31:0]   n_served_o;

   int n_vec  = 0;
   int n_fail = 0;
   int exp_q[$];

   wvb_rd_sched #(
      .P_N_CHAN     (N),
      .P_CHAN_WIDTH (CW),
      .P_TIMEOUT    (TO)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .en_i            (en_i),
      .hdr_empty_i     (hdr_empty_i),
      .chan_overflow_i (chan_overflow_i),
      .rd_start_o      (rd_start_o),
      .rd_chan_o       (rd_chan_o),
      .rd_busy_o       (rd_busy_o),
      .rd_done_i       (rd_done_i),
      .chan_rddone_o   (chan_rddone_o),
      .timeout_err_o   (timeout_err_o),
      .err_clr_i       (err_clr_i),
      .n_served_o      (n_served_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Waits (bounded) for rd_start, then checks rd_chan against the scoreboard.
   task automatic expect_start(input int budget, output int waited);
      int exp_ch;
      waited = 0;
      while (rd_start_o !== 1'b1 && waited < budget) begin
         step();
         waited++;
      end
      check("rd_start_seen", 64'(rd_start_o), 64'd1);
      if (rd_start_o === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("scoreboard_nonempty", 64'd0, 64'd1);
         end else begin
            exp_ch = exp_q.pop_front();
            check("rd_chan", 64'(rd_chan_o), 64'(exp_ch));
            check("rd_busy_at_start", 64'(rd_busy_o), 64'd1);
         end
      end
   endtask

   // Pulses rd_done; the DONE cycle must show the strobe and the new count.
   task automatic complete_ok(input int ch, input int served);
      logic [N-1:0] e;
      e     = '0;
      e[ch] = 1'b1;
      rd_done_i = 1'b1;
      step();
      rd_done_i = 1'b0;
      check("chan_rddone", 64'(chan_rddone_o), 64'(e));
      check("n_served", 64'(n_served_o), 64'(served));
      check("busy_in_done", 64'(rd_busy_o), 64'd1);
   endtask

   initial begin
      int w;
      int seen;
      logic [N-1:0] rdd_acc;
      int first_ch;
      int second_ch;
      int served_ch [5];

      served_ch = '{5, 23, 0, 5, 23};

      rst             = 1'b1;
      en_i            = 1'b0;
      hdr_empty_i     = '1;
      chan_overflow_i = '0;
      rd_done_i       = 1'b0;
      err_clr_i       = 1'b0;
      step();
      step();

      // Reset values
      check("rst_rd_start", 64'(rd_start_o), 64'd0);
      check("rst_rd_chan", 64'(rd_chan_o), 64'd0);
      check("rst_rd_busy", 64'(rd_busy_o), 64'd0);
      check("rst_chan_rddone", 64'(chan_rddone_o), 64'd0);
      check("rst_timeout_err", 64'(timeout_err_o), 64'd0);
      check("rst_n_served", 64'(n_served_o), 64'd0);
      rst = 1'b0;
      step();

      // Single request on ch3: IDLE -> ARB -> START, start in the third cycle
      en_i           = 1'b1;
      hdr_empty_i[3] = 1'b0;
      exp_q.push_back(3);
      step();
      check("t1_no_start_in_arb", 64'(rd_start_o), 64'd0);
      step();
      expect_start(0, w);
      step();
      check("t1_start_one_cycle", 64'(rd_start_o), 64'd0);
      hdr_empty_i[3] = 1'b1;
      complete_ok(3, 1);
      step();
      check("t1_rddone_one_cycle", 64'(chan_rddone_o), 64'd0);
      check("t1_busy_drop", 64'(rd_busy_o), 64'd0);

      // ch0, ch5, ch23 held non-empty; pointer now 4 -> order 5, 23, 0, 5, 23
      hdr_empty_i[0]  = 1'b0;
      hdr_empty_i[5]  = 1'b0;
      hdr_empty_i[23] = 1'b0;
      for (int i = 0; i < 5; i++) exp_q.push_back(served_ch[i]);
      expect_start(10, w);
      check("t2_idle_latency", 64'(w), 64'd2);
      for (int i = 0; i < 5; i++) begin
         for (int c = 0; c < 9; c++) step();
         check("t2_chan_stable", 64'(rd_chan_o), 64'(served_ch[i]));
         check("t2_busy_wait", 64'(rd_busy_o), 64'd1);
         complete_ok(served_ch[i], 2 + i);
         if (i < 4) begin
            // rd_done edge + 3 more edges (DONE, IDLE, ARB) before START
            expect_start(20, w);
            check("t2_b2b_gap", 64'(w), 64'd3);
         end
      end

      // en dropped during WAIT: readout completes, nothing new until en=1
      exp_q.push_back(0);
      expect_start(20, w);
      en_i = 1'b0;
      step();
      step();
      complete_ok(0, 7);
      seen = 0;
      for (int c = 0; c < 10; c++) begin
         step();
         if (rd_start_o === 1'b1) seen++;
      end
      check("t3_no_start_en_low", 64'(seen), 64'd0);
      check("t3_idle_busy", 64'(rd_busy_o), 64'd0);
      en_i = 1'b1;
      exp_q.push_back(5);
      expect_start(10, w);

      // Timeout on ch5: 16 WAIT cycles, then DONE with timeout_err, no strobe
      rdd_acc = '0;
      for (int c = 0; c < 16; c++) begin
         step();
         rdd_acc |= chan_rddone_o;
      end
      check("t4_no_err_yet", 64'(timeout_err_o), 64'd0);
      check("t4_busy_in_wait", 64'(rd_busy_o), 64'd1);
      step();
      rdd_acc |= chan_rddone_o;
      check("t4_timeout_err", 64'(timeout_err_o), 64'd1);
      check("t4_busy_in_done", 64'(rd_busy_o), 64'd1);
      check("t4_no_rddone", 64'(rdd_acc), 64'd0);
      step();
      check("t4_busy_drop", 64'(rd_busy_o), 64'd0);
      check("t4_n_served_hold", 64'(n_served_o), 64'd7);
      check("t4_err_sticky", 64'(timeout_err_o), 64'd1);
      err_clr_i = 1'b1;
      step();
      err_clr_i = 1'b0;
      check("t4_err_clr", 64'(timeout_err_o), 64'd0);
      // Pointer moved past ch5 even though it was aborted
      exp_q.push_back(23);
      expect_start(10, w);

      // Asynchronous reset in WAIT, between clock edges
      step();
      step();
      step();
      #2;
      rst = 1'b1;
      #1;
      check("t5_rst_rd_start", 64'(rd_start_o), 64'd0);
      check("t5_rst_rd_chan", 64'(rd_chan_o), 64'd0);
      check("t5_rst_rd_busy", 64'(rd_busy_o), 64'd0);
      check("t5_rst_chan_rddone", 64'(chan_rddone_o), 64'd0);
      check("t5_rst_n_served", 64'(n_served_o), 64'd0);
      step();
      step();
      rst = 1'b0;
      exp_q.push_back(0);
      expect_start(10, w);
      hdr_empty_i = '1;
      step();
      complete_ok(0, 1);

      // Request that disappears before ARB: back to IDLE, no start
      step();
      step();
      hdr_empty_i[9] = 1'b0;
      step();
      hdr_empty_i[9] = 1'b1;
      seen = 0;
      for (int c = 0; c < 8; c++) begin
         step();
         if (rd_start_o === 1'b1) seen++;
      end
      check("t6_no_start_on_drop", 64'(seen), 64'd0);
      check("t6_rd_chan_kept", 64'(rd_chan_o), 64'd0);

      // ch1 and ch7 pending, ch7 overflowing, pointer at 1
`ifdef WVB_OVF_PRIO_EN
      first_ch  = 7;
      second_ch = 1;
`else
      first_ch  = 1;
      second_ch = 7;
`endif
      chan_overflow_i[7] = 1'b1;
      hdr_empty_i[1]     = 1'b0;
      hdr_empty_i[7]     = 1'b0;
      exp_q.push_back(first_ch);
      exp_q.push_back(second_ch);
      expect_start(10, w);
      hdr_empty_i[first_ch] = 1'b1;
      step();
      complete_ok(first_ch, 2);
      expect_start(20, w);
      hdr_empty_i[second_ch] = 1'b1;
      step();
      complete_ok(second_ch, 3);
      step();
      check("t7_scoreboard_drained", 64'(exp_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule : tb_wvb_rd_sched
